// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM states, owner ids,
// grant bit positions, bus widths and the IO-space address decode.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbBusy = 2'd1,
    ArbDone = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnInf = 2'd0,
    OwnLd  = 2'd1,
    OwnSt  = 2'd2
  } owner_e;

  // Bit positions inside the one-hot grant vector
  localparam int GntInf = 0;
  localparam int GntLd  = 1;
  localparam int GntSt  = 2;
  localparam int GntW   = 3;

  // Address bits [17:16] equal to this value select IO space
  localparam logic [1:0] IOAddrHi = 2'b11;

  localparam logic Load  = 1'b0;
  localparam logic Store = 1'b1;

  localparam int LenBus  = 3;
  localparam int AddrBus = 32;
  localparam int DataBus = 32;

  // Instruction fetches are always a full 4-byte word
  localparam logic [LenBus-1:0] LenFetch = 3'd4;

  // True when the upper address bits point into IO space
  function automatic logic is_io_addr(input logic [1:0] addr_hi);
    return (addr_hi == IOAddrHi);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational requester picker: fixed priority ST > LD > INF, with a
// starvation override for fetch and an IO-backpressure block on stores.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic            inf_en,
  input  logic            ld_en,
  input  logic            st_en,
  input  logic [1:0]      st_addr_hi,
  input  logic            io_full,
  input  logic            starve,
  output logic [GntW-1:0] grant
);

  logic st_ok_s;

  // A store into IO space must wait while the IO buffer is full
  assign st_ok_s = st_en & ~(io_full & is_io_addr(st_addr_hi));

  // Pick exactly one requester, or none
  always_comb begin
    grant = 3'b000;
    if (inf_en && starve) begin
      grant[GntInf] = 1'b1;
    end else if (st_ok_s) begin
      grant[GntSt] = 1'b1;
    end else if (ld_en) begin
      grant[GntLd] = 1'b1;
    end else if (inf_en) begin
      grant[GntInf] = 1'b1;
    end else begin
      grant = 3'b000;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-way arbiter in front of the byte-serial memory sequencer. One
// transaction in flight at a time; fetch/load completions are dropped
// after a pipeline clear while the sequencer finishes the access.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = AddrBus,
  parameter int DATA_W       = DataBus,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              iIO_buffer_full,
  input  logic              iCLR,
  input  logic              iINF_en,
  input  logic [ADDR_W-1:0] iINF_addr,
  output logic              oINF_done,
  output logic [DATA_W-1:0] oINF_inst,
  input  logic              iLD_en,
  input  logic [ADDR_W-1:0] iLD_addr,
  input  logic [LenBus-1:0] iLD_len,
  output logic              oLD_done,
  output logic [DATA_W-1:0] oLD_dt,
  input  logic              iST_en,
  input  logic [ADDR_W-1:0] iST_addr,
  input  logic [LenBus-1:0] iST_len,
  input  logic [DATA_W-1:0] iST_dt,
  output logic              oST_done,
  output logic              oMC_en,
  output logic              oMC_ls,
  output logic [LenBus-1:0] oMC_len,
  output logic [ADDR_W-1:0] oMC_addr,
  output logic [DATA_W-1:0] oMC_dt,
  input  logic              iMC_done,
  input  logic [DATA_W-1:0] iMC_dt
);

  localparam int WcntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WcntW-1:0] WaitMax  = WcntW'(STARVE_LIMIT);
  localparam logic [WcntW-1:0] WaitOne  = WcntW'(32'd1);
  localparam logic [WcntW-1:0] WaitZero = WcntW'(32'd0);

  arb_state_e        state_r, state_nxt_s;
  owner_e            owner_r, owner_nxt_s;
  logic              kill_r, kill_nxt_s, kill_now_s;
  logic [WcntW-1:0]  wait_cnt_r, wait_nxt_s;
  logic [GntW-1:0]   grant_s;
  logic              grant_fire_s;
  logic              starve_s;
  logic              mc_en_nxt_s, mc_ls_nxt_s;
  logic [LenBus-1:0] mc_len_nxt_s;
  logic [ADDR_W-1:0] mc_addr_nxt_s;
  logic [DATA_W-1:0] mc_dt_nxt_s;
  logic              inf_done_nxt_s, ld_done_nxt_s, st_done_nxt_s;
  logic [DATA_W-1:0] inf_inst_nxt_s, ld_dt_nxt_s;

  assign starve_s     = (wait_cnt_r == WaitMax);
  assign grant_fire_s = (state_r == ArbIdle) & ~iCLR & (|grant_s);
  // A clear seen in the completion cycle still suppresses the pulse
  assign kill_now_s   = kill_r | (iCLR & (owner_r != OwnSt));

  mem_arb_pick u_pick (
    .inf_en     (iINF_en),
    .ld_en      (iLD_en),
    .st_en      (iST_en),
    .st_addr_hi (iST_addr[17:16]),
    .io_full    (iIO_buffer_full),
    .starve     (starve_s),
    .grant      (grant_s)
  );

  // Count LD/ST grants made while fetch is waiting; reset on fetch grant or idle fetch
  always_comb begin
    wait_nxt_s = wait_cnt_r;
    if (!iINF_en) begin
      wait_nxt_s = WaitZero;
    end else if (grant_fire_s && grant_s[GntInf]) begin
      wait_nxt_s = WaitZero;
    end else if (grant_fire_s && (wait_cnt_r != WaitMax)) begin
      wait_nxt_s = wait_cnt_r + WaitOne;
    end else begin
      wait_nxt_s = wait_cnt_r;
    end
  end

  // Next-state and next-output logic for the IDLE/BUSY/DONE sequencer
  always_comb begin
    state_nxt_s    = state_r;
    owner_nxt_s    = owner_r;
    kill_nxt_s     = kill_r;
    mc_en_nxt_s    = oMC_en;
    mc_ls_nxt_s    = oMC_ls;
    mc_len_nxt_s   = oMC_len;
    mc_addr_nxt_s  = oMC_addr;
    mc_dt_nxt_s    = oMC_dt;
    inf_done_nxt_s = oINF_done;
    ld_done_nxt_s  = oLD_done;
    st_done_nxt_s  = oST_done;
    inf_inst_nxt_s = oINF_inst;
    ld_dt_nxt_s    = oLD_dt;
    case (state_r)
      ArbIdle: begin
        if (grant_fire_s) begin
          state_nxt_s = ArbBusy;
          mc_en_nxt_s = 1'b1;
          if (grant_s[GntSt]) begin
            owner_nxt_s   = OwnSt;
            mc_ls_nxt_s   = Store;
            mc_len_nxt_s  = iST_len;
            mc_addr_nxt_s = iST_addr;
            mc_dt_nxt_s   = iST_dt;
          end else if (grant_s[GntLd]) begin
            owner_nxt_s   = OwnLd;
            mc_ls_nxt_s   = Load;
            mc_len_nxt_s  = iLD_len;
            mc_addr_nxt_s = iLD_addr;
            mc_dt_nxt_s   = {DATA_W{1'b0}};
          end else begin
            owner_nxt_s   = OwnInf;
            mc_ls_nxt_s   = Load;
            mc_len_nxt_s  = LenFetch;
            mc_addr_nxt_s = iINF_addr;
            mc_dt_nxt_s   = {DATA_W{1'b0}};
          end
        end else begin
          state_nxt_s = ArbIdle;
        end
      end
      ArbBusy: begin
        if (iMC_done) begin
          state_nxt_s = ArbDone;
          mc_en_nxt_s = 1'b0;
          kill_nxt_s  = 1'b0;
          if (kill_now_s) begin
            inf_done_nxt_s = 1'b0;
            ld_done_nxt_s  = 1'b0;
          end else begin
            case (owner_r)
              OwnInf: begin
                inf_done_nxt_s = 1'b1;
                inf_inst_nxt_s = iMC_dt;
              end
              OwnLd: begin
                ld_done_nxt_s = 1'b1;
                ld_dt_nxt_s   = iMC_dt;
              end
              OwnSt: begin
                st_done_nxt_s = 1'b1;
              end
              default: begin
                st_done_nxt_s = 1'b0;
              end
            endcase
          end
        end else begin
          state_nxt_s = ArbBusy;
          kill_nxt_s  = kill_now_s;
        end
      end
      ArbDone: begin
        state_nxt_s    = ArbIdle;
        inf_done_nxt_s = 1'b0;
        ld_done_nxt_s  = 1'b0;
        st_done_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s    = ArbIdle;
        mc_en_nxt_s    = 1'b0;
        kill_nxt_s     = 1'b0;
        inf_done_nxt_s = 1'b0;
        ld_done_nxt_s  = 1'b0;
        st_done_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; rdy low freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ArbIdle;
      owner_r    <= OwnInf;
      kill_r     <= 1'b0;
      wait_cnt_r <= WaitZero;
      oMC_en     <= 1'b0;
      oMC_ls     <= 1'b0;
      oMC_len    <= 3'd0;
      oMC_addr   <= {ADDR_W{1'b0}};
      oMC_dt     <= {DATA_W{1'b0}};
      oINF_done  <= 1'b0;
      oLD_done   <= 1'b0;
      oST_done   <= 1'b0;
      oINF_inst  <= {DATA_W{1'b0}};
      oLD_dt     <= {DATA_W{1'b0}};
    end else if (rdy) begin
      state_r    <= state_nxt_s;
      owner_r    <= owner_nxt_s;
      kill_r     <= kill_nxt_s;
      wait_cnt_r <= wait_nxt_s;
      oMC_en     <= mc_en_nxt_s;
      oMC_ls     <= mc_ls_nxt_s;
      oMC_len    <= mc_len_nxt_s;
      oMC_addr   <= mc_addr_nxt_s;
      oMC_dt     <= mc_dt_nxt_s;
      oINF_done  <= inf_done_nxt_s;
      oLD_done   <= ld_done_nxt_s;
      oST_done   <= st_done_nxt_s;
      oINF_inst  <= inf_inst_nxt_s;
      oLD_dt     <= ld_dt_nxt_s;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs change and outputs
// are sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, rdy, iIO_buffer_full, iCLR;
  logic        iINF_en, iLD_en, iST_en, iMC_done;
  logic [31:0] iINF_addr, iLD_addr, iST_addr, iST_dt, iMC_dt;
  logic [2:0]  iLD_len, iST_len;
  logic        oINF_done, oLD_done, oST_done, oMC_en, oMC_ls;
  logic [31:0] oINF_inst, oLD_dt, oMC_addr, oMC_dt;
  logic [2:0]  oMC_len;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .iIO_buffer_full(iIO_buffer_full), .iCLR(iCLR),
    .iINF_en(iINF_en), .iINF_addr(iINF_addr), .oINF_done(oINF_done), .oINF_inst(oINF_inst),
    .iLD_en(iLD_en), .iLD_addr(iLD_addr), .iLD_len(iLD_len), .oLD_done(oLD_done), .oLD_dt(oLD_dt),
    .iST_en(iST_en), .iST_addr(iST_addr), .iST_len(iST_len), .iST_dt(iST_dt), .oST_done(oST_done),
    .oMC_en(oMC_en), .oMC_ls(oMC_ls), .oMC_len(oMC_len), .oMC_addr(oMC_addr), .oMC_dt(oMC_dt),
    .iMC_done(iMC_done), .iMC_dt(iMC_dt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  // Sequencer completion: pulse iMC_done for one cycle, return at the DONE-state sample point
  task automatic finish_txn(input logic [31:0] d);
    iMC_done = 1'b1;
    iMC_dt   = d;
    tick;
    iMC_done = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++; if (oMC_en !== 1'b0 || oMC_ls !== 1'b0) begin n_fail++; $display("FAIL reset_mc_en_ls: got %b%b expected 00", oMC_en, oMC_ls); end
    n_checks++; if (oMC_len !== 3'd0 || oMC_addr !== 32'h0 || oMC_dt !== 32'h0) begin n_fail++; $display("FAIL reset_mc_payload: got len %0d addr %h dt %h expected zeros", oMC_len, oMC_addr, oMC_dt); end
    n_checks++; if ({oINF_done, oLD_done, oST_done} !== 3'b000) begin n_fail++; $display("FAIL reset_done: got %b expected 000", {oINF_done, oLD_done, oST_done}); end
    n_checks++; if (oINF_inst !== 32'h0 || oLD_dt !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h %h expected 0 0", oINF_inst, oLD_dt); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single_fetch;
    iINF_en = 1'b1; iINF_addr = 32'h1000;
    tick;
    n_checks++; if (oMC_addr !== 32'h1000 || oMC_len !== 3'd4 || oMC_ls !== 1'b0) begin n_fail++; $display("FAIL fetch_cmd: got addr %h len %0d ls %b expected 1000 4 0", oMC_addr, oMC_len, oMC_ls); end
    for (int c = 1; c <= 4; c++) begin
      n_checks++; if (oMC_en !== 1'b1 || oINF_done !== 1'b0) begin n_fail++; $display("FAIL fetch_busy_c%0d: got en %b done %b expected 1 0", c, oMC_en, oINF_done); end
      if (c == 4) begin
        iMC_done = 1'b1; iMC_dt = 32'h00A00093;
      end
      tick;
    end
    iMC_done = 1'b0;
    n_checks++; if (oINF_done !== 1'b1 || oINF_inst !== 32'h00A00093 || oMC_en !== 1'b0) begin n_fail++; $display("FAIL fetch_done_c5: got done %b inst %h en %b expected 1 00a00093 0", oINF_done, oINF_inst, oMC_en); end
    iINF_en = 1'b0;
    tick;
    n_checks++; if (oINF_done !== 1'b0 || oMC_en !== 1'b0) begin n_fail++; $display("FAIL fetch_idle_c6: got done %b en %b expected 0 0", oINF_done, oMC_en); end
    tick;
    n_checks++; if (oMC_en !== 1'b0) begin n_fail++; $display("FAIL fetch_no_regrant: got en %b expected 0", oMC_en); end
  endtask

  task automatic test_priority;
    iST_en = 1'b1; iST_addr = 32'h200; iST_len = 3'd2; iST_dt = 32'hBEEF;
    iLD_en = 1'b1; iLD_addr = 32'h300; iLD_len = 3'd1;
    iINF_en = 1'b1; iINF_addr = 32'h400;
    tick;
    n_checks++; if (oMC_ls !== 1'b1 || oMC_len !== 3'd2 || oMC_addr !== 32'h200 || oMC_dt !== 32'hBEEF) begin n_fail++; $display("FAIL prio_st_cmd: got ls %b len %0d addr %h dt %h expected 1 2 200 beef", oMC_ls, oMC_len, oMC_addr, oMC_dt); end
    finish_txn(32'h0);
    n_checks++; if ({oINF_done, oLD_done, oST_done} !== 3'b001) begin n_fail++; $display("FAIL prio_st_done: got %b expected 001", {oINF_done, oLD_done, oST_done}); end
    iST_en = 1'b0;
    tick;
    n_checks++; if (oMC_en !== 1'b0) begin n_fail++; $display("FAIL prio_idle_gap: got en %b expected 0", oMC_en); end
    tick;
    n_checks++; if (oMC_ls !== 1'b0 || oMC_len !== 3'd1 || oMC_addr !== 32'h300) begin n_fail++; $display("FAIL prio_ld_cmd: got ls %b len %0d addr %h expected 0 1 300", oMC_ls, oMC_len, oMC_addr); end
    finish_txn(32'h5A);
    n_checks++; if ({oINF_done, oLD_done, oST_done} !== 3'b010 || oLD_dt !== 32'h5A) begin n_fail++; $display("FAIL prio_ld_done: got %b dt %h expected 010 5a", {oINF_done, oLD_done, oST_done}, oLD_dt); end
    iLD_en = 1'b0;
    tick;
    tick;
    n_checks++; if (oMC_en !== 1'b1 || oMC_len !== 3'd4 || oMC_addr !== 32'h400) begin n_fail++; $display("FAIL prio_inf_cmd: got en %b len %0d addr %h expected 1 4 400", oMC_en, oMC_len, oMC_addr); end
    finish_txn(32'h13);
    n_checks++; if ({oINF_done, oLD_done, oST_done} !== 3'b100 || oINF_inst !== 32'h13) begin n_fail++; $display("FAIL prio_inf_done: got %b inst %h expected 100 13", {oINF_done, oLD_done, oST_done}, oINF_inst); end
    iINF_en = 1'b0;
    tick;
  endtask

  task automatic test_starvation;
    logic exp_ls;
    iINF_en = 1'b1; iINF_addr = 32'h500;
    iST_en = 1'b1; iST_addr = 32'h600; iST_len = 3'd4; iST_dt = 32'h11;
    iLD_en = 1'b0; iLD_addr = 32'h700; iLD_len = 3'd4;
    tick;
    for (int i = 0; i < 4; i++) begin
      exp_ls = (i % 2 == 0);
      n_checks++; if (oMC_en !== 1'b1 || oMC_ls !== exp_ls) begin n_fail++; $display("FAIL starve_grant%0d: got en %b ls %b expected 1 %b", i, oMC_en, oMC_ls, exp_ls); end
      finish_txn(32'h0);
      if (i % 2 == 0) begin iST_en = 1'b0; iLD_en = 1'b1; end
      else begin iLD_en = 1'b0; iST_en = 1'b1; end
      tick;
      tick;
    end
    n_checks++; if (oMC_ls !== 1'b0 || oMC_len !== 3'd4 || oMC_addr !== 32'h500) begin n_fail++; $display("FAIL starve_inf_wins: got ls %b len %0d addr %h expected 0 4 500", oMC_ls, oMC_len, oMC_addr); end
    finish_txn(32'h99);
    n_checks++; if ({oINF_done, oLD_done, oST_done} !== 3'b100) begin n_fail++; $display("FAIL starve_inf_done: got %b expected 100", {oINF_done, oLD_done, oST_done}); end
    iINF_en = 1'b0;
    tick;
    tick;
    n_checks++; if (oMC_ls !== 1'b1 || oMC_addr !== 32'h600) begin n_fail++; $display("FAIL starve_st_after: got ls %b addr %h expected 1 600", oMC_ls, oMC_addr); end
    finish_txn(32'h0);
    n_checks++; if ({oINF_done, oLD_done, oST_done} !== 3'b001) begin n_fail++; $display("FAIL starve_st_done: got %b expected 001", {oINF_done, oLD_done, oST_done}); end
    iST_en = 1'b0;
    tick;
  endtask

  task automatic test_io_backpressure;
    iIO_buffer_full = 1'b1;
    iST_en = 1'b1; iST_addr = 32'h30000; iST_len = 3'd1; iST_dt = 32'h41;
    iLD_en = 1'b1; iLD_addr = 32'h740; iLD_len = 3'd2;
    tick;
    n_checks++; if (oMC_ls !== 1'b0 || oMC_addr !== 32'h740) begin n_fail++; $display("FAIL io_ld_first: got ls %b addr %h expected 0 740", oMC_ls, oMC_addr); end
    finish_txn(32'h1234);
    n_checks++; if ({oINF_done, oLD_done, oST_done} !== 3'b010) begin n_fail++; $display("FAIL io_ld_done: got %b expected 010", {oINF_done, oLD_done, oST_done}); end
    iLD_en = 1'b0;
    tick;
    tick;
    n_checks++; if (oMC_en !== 1'b0) begin n_fail++; $display("FAIL io_st_blocked: got en %b expected 0", oMC_en); end
    iIO_buffer_full = 1'b0;
    tick;
    n_checks++; if (oMC_en !== 1'b1 || oMC_ls !== 1'b1 || oMC_addr !== 32'h30000) begin n_fail++; $display("FAIL io_st_released: got en %b ls %b addr %h expected 1 1 30000", oMC_en, oMC_ls, oMC_addr); end
    finish_txn(32'h0);
    n_checks++; if ({oINF_done, oLD_done, oST_done} !== 3'b001) begin n_fail++; $display("FAIL io_st_done: got %b expected 001", {oINF_done, oLD_done, oST_done}); end
    iST_en = 1'b0;
    tick;
  endtask

  task automatic test_clear;
    iLD_en = 1'b1; iLD_addr = 32'h800; iLD_len = 3'd4; iCLR = 1'b1;
    tick;
    n_checks++; if (oMC_en !== 1'b0) begin n_fail++; $display("FAIL clr_idle_nogrant: got en %b expected 0", oMC_en); end
    iCLR = 1'b0;
    tick;
    n_checks++; if (oMC_en !== 1'b1) begin n_fail++; $display("FAIL clr_ld_grant: got en %b expected 1", oMC_en); end
    iCLR = 1'b1;
    tick;
    iCLR = 1'b0;
    n_checks++; if (oMC_en !== 1'b1 || oMC_addr !== 32'h800) begin n_fail++; $display("FAIL clr_ld_held: got en %b addr %h expected 1 800", oMC_en, oMC_addr); end
    finish_txn(32'hDEAD);
    n_checks++; if ({oINF_done, oLD_done, oST_done} !== 3'b000 || oMC_en !== 1'b0) begin n_fail++; $display("FAIL clr_ld_killed: got done %b en %b expected 000 0", {oINF_done, oLD_done, oST_done}, oMC_en); end
    iLD_en = 1'b0;
    tick;
    iST_en = 1'b1; iST_addr = 32'h900; iST_len = 3'd4; iST_dt = 32'hCAFE;
    tick;
    iCLR = 1'b1;
    tick;
    iCLR = 1'b0;
    finish_txn(32'h0);
    n_checks++; if ({oINF_done, oLD_done, oST_done} !== 3'b001) begin n_fail++; $display("FAIL clr_st_survives: got %b expected 001", {oINF_done, oLD_done, oST_done}); end
    iST_en = 1'b0;
    tick;
    iINF_en = 1'b1; iINF_addr = 32'hA00;
    tick;
    iCLR = 1'b1;
    finish_txn(32'h5555);
    iCLR = 1'b0;
    n_checks++; if ({oINF_done, oLD_done, oST_done} !== 3'b000) begin n_fail++; $display("FAIL clr_same_cycle: got %b expected 000", {oINF_done, oLD_done, oST_done}); end
    iINF_en = 1'b0;
    tick;
    iLD_en = 1'b1; iLD_addr = 32'hA40; iLD_len = 3'd2;
    tick;
    finish_txn(32'h66);
    n_checks++; if ({oINF_done, oLD_done, oST_done} !== 3'b010 || oLD_dt !== 32'h66) begin n_fail++; $display("FAIL clr_kill_cleared: got %b dt %h expected 010 66", {oINF_done, oLD_done, oST_done}, oLD_dt); end
    iLD_en = 1'b0;
    tick;
  endtask

  task automatic test_reset_and_stall;
    iLD_en = 1'b1; iLD_addr = 32'hB00; iLD_len = 3'd2;
    tick;
    n_checks++; if (oMC_en !== 1'b1) begin n_fail++; $display("FAIL rst_busy_setup: got en %b expected 1", oMC_en); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (oMC_en !== 1'b0 || oMC_addr !== 32'h0 || oMC_len !== 3'd0) begin n_fail++; $display("FAIL rst_async_mc: got en %b addr %h len %0d expected 0 0 0", oMC_en, oMC_addr, oMC_len); end
    n_checks++; if (oLD_dt !== 32'h0 || oINF_inst !== 32'h0) begin n_fail++; $display("FAIL rst_async_data: got %h %h expected 0 0", oLD_dt, oINF_inst); end
    iLD_en = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    iLD_en = 1'b1; iLD_addr = 32'hB40; iLD_len = 3'd1;
    tick;
    finish_txn(32'h77);
    n_checks++; if (oLD_done !== 1'b1) begin n_fail++; $display("FAIL stall_done_first: got %b expected 1", oLD_done); end
    iLD_en = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_checks++; if (oLD_done !== 1'b1 || oLD_dt !== 32'h77) begin n_fail++; $display("FAIL stall_hold%0d: got done %b dt %h expected 1 77", i, oLD_done, oLD_dt); end
    end
    rdy = 1'b1;
    tick;
    n_checks++; if (oLD_done !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b expected 0", oLD_done); end
    tick;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; iIO_buffer_full = 1'b0; iCLR = 1'b0;
    iINF_en = 1'b0; iINF_addr = 32'h0; iLD_en = 1'b0; iLD_addr = 32'h0; iLD_len = 3'd0;
    iST_en = 1'b0; iST_addr = 32'h0; iST_len = 3'd0; iST_dt = 32'h0;
    iMC_done = 1'b0; iMC_dt = 32'h0;
    tick;
    tick;
    test_reset;
    test_single_fetch;
    test_priority;
    test_starvation;
    test_io_backpressure;
    test_clear;
    test_reset_and_stall;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
